// File: rtl/candy_div_ctrl.sv
// candy_div_ctrl: round-robin sequencer between two requesters and one shared iterative divider
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_signed/req_flush [1:0], req_op1/req_op2 [2*DATA_W-1:0] (port1 in upper half)
//   rsp_valid/rsp_ready/rsp_id/rsp_dz, rsp_quot/rsp_rem [DATA_W-1:0]
//   div_start/div_annul/div_signed/div_op1/div_op2 to the divider; div_ready/div_quot/div_rem from it
// Option: CANDY_DIVCTRL_ZERO_BYPASS_EN answers op2==0 locally (quot all ones, rem=op1, rsp_dz=1)
module candy_div_ctrl #(
  parameter int DATA_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_signed,
  input  logic [2*DATA_W-1:0]   req_op1,
  input  logic [2*DATA_W-1:0]   req_op2,
  input  logic [1:0]            req_flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_quot,
  output logic [DATA_W-1:0]     rsp_rem,
  output logic                  rsp_dz,
  output logic                  div_start,
  output logic                  div_annul,
  output logic                  div_signed,
  output logic [DATA_W-1:0]     div_op1,
  output logic [DATA_W-1:0]     div_op2,
  input  logic                  div_ready,
  input  logic [DATA_W-1:0]     div_quot,
  input  logic [DATA_W-1:0]     div_rem
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t r_state, w_next;
  logic r_rr, r_id, r_signed, r_dz;
  logic [DATA_W-1:0] r_op1, r_op2, r_quot, r_rem;
  logic w_gnt, w_gnt_id, w_flush, w_zero, w_s;
  logic [DATA_W-1:0] w_a, w_b;
  // the rr pointer names the preferred port; the other one wins only when the preferred is idle
  assign w_gnt_id = req_valid[r_rr] ? r_rr : ~r_rr;
  assign w_gnt    = (r_state == IDLE) && (|req_valid);
  assign w_flush  = req_flush[r_id];
  assign w_s      = req_signed[w_gnt_id];
  assign w_a      = w_gnt_id ? req_op1[2*DATA_W-1:DATA_W] : req_op1[DATA_W-1:0];
  assign w_b      = w_gnt_id ? req_op2[2*DATA_W-1:DATA_W] : req_op2[DATA_W-1:0];
`ifdef CANDY_DIVCTRL_ZERO_BYPASS_EN
  assign w_zero = (w_b == '0);
`else
  assign w_zero = 1'b0;
`endif
  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    div_start = 1'b0;
    div_annul = 1'b0;
    case (r_state)
      IDLE: if (w_gnt) begin
        // gated by rst so every output reads 0 while reset is held
        req_ready[w_gnt_id] = rst;
        w_next = w_zero ? RESP : BUSY;
      end
      BUSY: begin
        // a flush beats a same-cycle div_ready: the result is dropped
        div_start = ~w_flush;
        div_annul = w_flush;
        w_next = w_flush ? IDLE : (div_ready ? RESP : BUSY);
      end
      RESP: w_next = (w_flush || rsp_ready) ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rr     <= 1'b0;
      r_id     <= 1'b0;
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt) begin
        r_id     <= w_gnt_id;
        r_rr     <= ~w_gnt_id;
        r_signed <= w_s;
        r_op1    <= w_a;
        r_op2    <= w_b;
        r_dz     <= w_zero;
        if (w_zero) begin
          r_quot <= '1;
          r_rem  <= w_a;
        end
      end
      if (r_state == BUSY && div_ready && !w_flush) begin
        r_quot <= div_quot;
        r_rem  <= div_rem;
        r_dz   <= 1'b0;
      end
    end
  end
  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_id;
  assign rsp_quot   = r_quot;
  assign rsp_rem    = r_rem;
  assign rsp_dz     = r_dz;
  assign div_signed = r_signed;
  assign div_op1    = r_op1;
  assign div_op2    = r_op2;
endmodule
